result_wb_fifo: RTL and testbench
=================================

RESULT_WB_FIFO -- requirements
Module: result_wb_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of result entries; legal values 2, 4, 8 (power of two).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: flush  input  1  synchronous discard of all buffered entries.
REQ-005 SHALL have port: in_valid  input  1  upstream result-mux output is valid this cycle.
REQ-006 SHALL have port: in_ready  output  1  buffer can accept an entry this cycle.
REQ-007 SHALL have port: in_data  input  16  selected ALU result from the 4:1 result mux.
REQ-008 SHALL have port: in_sel  input  3  operation select that produced in_data, carried as a tag.
REQ-009 SHALL have port: in_rd  input  3  destination register index.
REQ-010 SHALL have port: out_valid  output  1  head entry available to the writeback port.
REQ-011 SHALL have port: out_ready  input  1  writeback consumes head entry this cycle.
REQ-012 SHALL have ports: out_data  output  16, out_sel  output  3, out_rd  output  3; head entry fields.
REQ-013 SHALL have port: count  output  4  number of stored entries, 0..DEPTH.

Function
REQ-014 Push SHALL occur on a rising edge when in_valid && in_ready && !flush; the entry {in_data, in_sel, in_rd} is written at the write pointer.
REQ-015 Pop SHALL occur on a rising edge when out_valid && out_ready && !flush; the read pointer advances.
REQ-016 in_ready SHALL equal (count < DEPTH) and SHALL be combinational from registered state only (no path from out_ready).
REQ-017 out_valid SHALL equal (count != 0); the head fields SHALL be first-word-fall-through, with data visible the cycle after its push (latency 1 cycle, no same-cycle bypass).
REQ-018 When count == 0, out_data, out_sel, and out_rd SHALL be driven 0.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; at count == DEPTH no push occurs (in_ready low) even if a pop occurs in the same cycle.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO across wrap.
REQ-021 A push with in_valid high and in_ready low SHALL be ignored; upstream holds its data.
REQ-022 flush SHALL set count and both pointers to 0 on the next edge, overriding any push or pop in that cycle.
REQ-023 count SHALL update as count + push - pop, never exceeding DEPTH or going below 0.

Reset
REQ-024 On a rising edge with rst_n == 0: count = 0, pointers = 0, out_valid = 0, in_ready = 1 after the edge, out_data/out_sel/out_rd = 0.
REQ-025 Reset SHALL take priority over flush, push, and pop; entries in flight mid-operation are discarded.
REQ-026 Storage array contents need not be reset; they are never visible while count == 0.

Configuration
REQ-027 Macro RESULT_WB_FLAGS_EN: when defined, the module SHALL add outputs out_zero (1) and out_neg (1), computed at push time as (in_data == 0) and in_data[15], stored per entry, follow the head entry, and read 0 when empty or in reset.
REQ-028 When RESULT_WB_FLAGS_EN is not defined, out_zero and out_neg SHALL NOT exist, and no flag storage SHALL be present.

Verification
REQ-029 Reset, then push {0x1234, sel 1, rd 3}, out_ready low -> next cycle out_valid=1, out_data=0x1234, out_sel=1, out_rd=3, count=1.
REQ-030 Push 4 entries 0xA000..0xA003 with out_ready low, then hold in_valid -> count=4, in_ready=0, 5th entry dropped; drain yields 0xA000..0xA003 in order.
REQ-031 At count=4, in_valid=1, out_ready=1 for one cycle -> pop only, count=3, and in_ready=1 on the next cycle.
REQ-032 Continuous push and pop with 10 entries 0x0001..0x000A -> outputs in order across pointer wrap, count stable at 1.
REQ-033 With 3 entries stored, flush=1 together with in_valid=1 -> count=0, out_valid=0, out_data=0 next cycle; the concurrent entry is not stored.
REQ-034 With RESULT_WB_FLAGS_EN, push 0x0000 then 0x8001 -> head flags zero=1/neg=0, then zero=0/neg=1; with rst_n=0 mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/result_wb_fifo.sv
// -----------------------------------------------------------------------------
// result_wb_fifo
// Small first-word-fall-through buffer between the ALU result mux and the
// register-file writeback port. Each entry carries the result, the operation
// select that produced it, and the destination register index.
//
// Optional feature macro: RESULT_WB_FLAGS_EN
//   When defined, zero/negative flags are captured at push time, stored per
//   entry and presented with the head entry on out_zero / out_neg.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   flush               discard all buffered entries on the next edge
//   in_valid/in_ready   upstream handshake (in_ready from registered state only)
//   in_data/sel/rd      entry payload
//   out_valid/out_ready writeback handshake
//   out_data/sel/rd     head entry fields, 0 when empty
//   out_zero/out_neg    head entry flags (RESULT_WB_FLAGS_EN only)
//   count               number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module result_wb_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [2:0]  in_sel,
    input  logic [2:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_sel,
    output logic [2:0]  out_rd,
`ifdef RESULT_WB_FLAGS_EN
    output logic        out_zero,
    output logic        out_neg,
`endif
    output logic [3:0]  count
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned RD_W   = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
        logic [RD_W-1:0]   rd;
`ifdef RESULT_WB_FLAGS_EN
        logic              zero;
        logic              neg;
`endif
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push;
    logic               pop;
    entry_t             head;
    entry_t             wr_entry;

    // Handshake status depends only on the registered occupancy.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Entry to store, flags computed from the incoming result.
    always_comb begin
        wr_entry      = '0;
        wr_entry.data = in_data;
        wr_entry.sel  = in_sel;
        wr_entry.rd   = in_rd;
`ifdef RESULT_WB_FLAGS_EN
        wr_entry.zero = (in_data == '0);
        wr_entry.neg  = in_data[DATA_W-1];
`endif
    end

    // Head presentation; stale storage is masked while empty.
    always_comb begin
        head     = out_valid ? mem_q[rd_ptr_q] : '0;
        out_data = head.data;
        out_sel  = head.sel;
        out_rd   = head.rd;
`ifdef RESULT_WB_FLAGS_EN
        out_zero = head.zero;
        out_neg  = head.neg;
`endif
    end

    // Pointer and occupancy next state; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are not reset since they are masked when empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_result_wb_fifo.sv
// -----------------------------------------------------------------------------
// tb_result_wb_fifo
// Randomized and directed stimulus; a monitor holds a queue-based reference
// model of the buffer and compares every visible output each cycle.
// -----------------------------------------------------------------------------
module tb_result_wb_fifo;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic [2:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_sel;
    logic [2:0]  out_rd;
`ifdef RESULT_WB_FLAGS_EN
    logic        out_zero;
    logic        out_neg;
`endif
    logic [3:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  sel;
        logic [2:0]  rd;
    } exp_t;

    exp_t sb[$];
    bit   model_valid = 1'b0;

    result_wb_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_rd    (out_rd),
`ifdef RESULT_WB_FLAGS_EN
        .out_zero  (out_zero),
        .out_neg   (out_neg),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge.
    task automatic drive(input bit rst, input bit fl, input bit iv, input bit ordy,
                         input logic [15:0] d, input logic [2:0] s, input logic [2:0] r);
        @(negedge clk);
        rst_n     = ~rst;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_data   = d;
        in_sel    = s;
        in_rd     = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 16'h0, 3'd0, 3'd0);
    endtask

    // Monitor / scoreboard: compare outputs against the model, then advance it.
    initial begin : monitor
        int          pre;
        exp_t        h;
        logic [15:0] ed;
        logic [2:0]  es, er;
        while (!done) begin
            @(negedge clk);
            #2;
            if (model_valid) begin
                pre = sb.size();
                chk("count", 32'(count), 32'(pre));
                chk("in_ready", 32'(in_ready), 32'(pre < DEPTH));
                chk("out_valid", 32'(out_valid), 32'(pre != 0));
                ed = 16'h0; es = 3'd0; er = 3'd0;
                if (pre != 0) begin
                    h = sb[0];
                    ed = h.data; es = h.sel; er = h.rd;
                end
                chk("out_data", 32'(out_data), 32'(ed));
                chk("out_sel", 32'(out_sel), 32'(es));
                chk("out_rd", 32'(out_rd), 32'(er));
`ifdef RESULT_WB_FLAGS_EN
                chk("out_zero", 32'(out_zero), 32'((pre != 0) && (ed == 16'h0)));
                chk("out_neg", 32'(out_neg), 32'(ed[15]));
`endif
            end
            // Model update for the coming rising edge.
            if (!rst_n) begin
                sb.delete();
                model_valid = 1'b1;
            end else if (model_valid) begin
                pre = sb.size();
                if (flush) begin
                    sb.delete();
                end else begin
                    if (pre != 0 && out_ready) void'(sb.pop_front());
                    if (in_valid && pre < DEPTH) begin
                        h.data = in_data; h.sel = in_sel; h.rd = in_rd;
                        sb.push_back(h);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_sel = '0; in_rd = '0;
        drive(1, 0, 0, 0, 16'h0, 3'd0, 3'd0);
        drive(1, 0, 1, 1, 16'hFFFF, 3'd7, 3'd7);
        idle(1);

        // Single push, observed one cycle later.
        drive(0, 0, 1, 0, 16'h1234, 3'd1, 3'd3);
        idle(1);
        drive(0, 0, 0, 1, 16'h0, 3'd0, 3'd0);
        idle(1);

        // Fill to full, hold a fifth entry, then drain.
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 16'hA000 + 16'(i), 3'(i), 3'(i + 1));
        drive(0, 0, 1, 0, 16'hA004, 3'd4, 3'd5);
        drive(0, 0, 1, 0, 16'hA004, 3'd4, 3'd5);
        // Full with push request and pop: pop only.
        drive(0, 0, 1, 1, 16'hA004, 3'd4, 3'd5);
        drive(0, 0, 0, 0, 16'h0, 3'd0, 3'd0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 16'h0, 3'd0, 3'd0);
        idle(1);

        // Streaming across pointer wrap.
        for (int i = 1; i <= 10; i++) drive(0, 0, 1, 1, 16'(i), 3'(i), 3'(i + 2));
        drive(0, 0, 0, 1, 16'h0, 3'd0, 3'd0);
        idle(1);

        // Flush with concurrent push.
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 16'hB000 + 16'(i), 3'd2, 3'(i));
        drive(0, 1, 1, 1, 16'hBEEF, 3'd5, 3'd6);
        idle(2);

        // Flag values, then reset mid-stream.
        drive(0, 0, 1, 0, 16'h0000, 3'd3, 3'd1);
        drive(0, 0, 1, 0, 16'h8001, 3'd4, 3'd2);
        drive(0, 0, 0, 1, 16'h0, 3'd0, 3'd0);
        drive(0, 0, 1, 0, 16'h7FFF, 3'd6, 3'd4);
        drive(1, 0, 1, 1, 16'h5555, 3'd1, 3'd1);
        idle(2);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(99) == 0), ($urandom_range(24) == 0),
                  $urandom_range(1), ($urandom_range(2) != 0),
                  ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom),
                  3'($urandom), 3'($urandom));
        end
        drive(0, 0, 0, 1, 16'h0, 3'd0, 3'd0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 16'h0, 3'd0, 3'd0);
        idle(1);
        done = 1'b1;
        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
